// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the COCO timer sequencer: register map, CTRL layout,
// sequencer states and the command/bus payload types.
package timer_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned MODE_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'b10;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PRESET,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_RD_COUNT,
        ST_DISABLE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] preset;
        logic [MODE_W-1:0] mode;
        logic              wait_irq;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_t;

    // CTRL word that starts the timer with its interrupt enabled
    function automatic logic [DATA_W-1:0] ctrl_word(input logic [MODE_W-1:0] mode);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_EN] = 1'b1;
        w[CTRL_MODE_LSB +: MODE_W] = mode;
        w[CTRL_IM] = 1'b1;
        return w;
    endfunction

    // Timer bus access implied by a sequencer state
    function automatic bus_t bus_decode(input state_t st, input cmd_t c);
        bus_t b;
        b.addr  = ADDR_CTRL;
        b.we    = 1'b0;
        b.wdata = '0;
        case (st)
            ST_WR_PRESET: begin
                b.addr  = ADDR_PRESET;
                b.we    = 1'b1;
                b.wdata = c.preset;
            end
            ST_WR_CTRL: begin
                b.we    = 1'b1;
                b.wdata = ctrl_word(c.mode);
            end
            ST_RD_COUNT: b.addr = ADDR_COUNT;
            ST_DISABLE:  b.we   = 1'b1;
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_watchdog.sv
// Cycle counter for the IRQ wait; flags the last permitted cycle.
module timer_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = en && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/timer_sequencer.sv
// Runs the PRESET/CTRL/wait/COUNT/disable register sequence on the COCO timer
// for one command and returns a single response.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_preset,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic              cmd_wait,
    input  logic              abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_count,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] tmr_addr,
    output logic              tmr_we,
    output logic [DATA_W-1:0] tmr_wdata,
    input  logic [DATA_W-1:0] tmr_rdata,
    input  logic              tmr_irq
);

    state_t            state, state_next;
    cmd_t              cmd, cmd_next;
    logic              aborted, aborted_next;
    logic [DATA_W-1:0] count_next;
    logic              timeout_next;
    bus_t              bus_next;
    logic              accept;
    logic              in_wait;
    logic              wd_expire;

    assign accept  = cmd_valid & cmd_ready;
    assign in_wait = (state == ST_WAIT_IRQ);

    timer_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (~in_wait),
        .en      (in_wait),
        .expire_c(wd_expire)
    );

    // Next state, response capture and the bus access of the next state
    always_comb begin
        state_next   = state;
        aborted_next = aborted;
        count_next   = rsp_count;
        timeout_next = rsp_timeout;
        cmd_next     = cmd;
        if (accept) begin
            cmd_next = '{preset: cmd_preset, mode: cmd_mode, wait_irq: cmd_wait};
        end
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_WR_PRESET;
                    aborted_next = 1'b0;
                end
            end
            ST_WR_PRESET: begin
                state_next = ST_WR_CTRL;
                if (abort) begin
                    state_next   = ST_DISABLE;
                    aborted_next = 1'b1;
                end
            end
            ST_WR_CTRL: begin
                if (abort) begin
                    state_next   = ST_DISABLE;
                    aborted_next = 1'b1;
                end else if (cmd.wait_irq) begin
                    state_next = ST_WAIT_IRQ;
                end else begin
                    state_next   = ST_RESP;
                    count_next   = cmd.preset;
                    timeout_next = 1'b0;
                end
            end
            ST_WAIT_IRQ: begin
                // Priority: abort, then IRQ, then watchdog
                if (abort) begin
                    state_next   = ST_DISABLE;
                    aborted_next = 1'b1;
                end else if (tmr_irq) begin
                    state_next   = ST_RD_COUNT;
                    timeout_next = 1'b0;
                end else if (wd_expire) begin
                    state_next   = ST_RD_COUNT;
                    timeout_next = 1'b1;
                end
            end
            ST_RD_COUNT: begin
                state_next = ST_DISABLE;
                if (abort) begin
                    aborted_next = 1'b1;
                end else begin
                    count_next = tmr_rdata;
                end
            end
            ST_DISABLE: begin
                state_next = aborted ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        bus_next = bus_decode(state_next, cmd_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            aborted     <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_count   <= '0;
            rsp_timeout <= 1'b0;
            tmr_addr    <= ADDR_CTRL;
            tmr_we      <= 1'b0;
            tmr_wdata   <= '0;
        end else begin
            state       <= state_next;
            cmd         <= cmd_next;
            aborted     <= aborted_next;
            cmd_ready   <= (state_next == ST_IDLE);
            rsp_valid   <= (state_next == ST_RESP);
            rsp_count   <= count_next;
            rsp_timeout <= timeout_next;
            tmr_addr    <= bus_next.addr;
            tmr_we      <= bus_next.we;
            tmr_wdata   <= bus_next.wdata;
        end
    end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

CPU-side initiator that programs and services the COCO timer over its register bus (addr[3:2], we, datain, dataout, IRQ). It accepts a one-shot timing command through a valid/ready port and runs the full register sequence autonomously: write PRESET, write CTRL, wait for IRQ under a watchdog, read COUNT, then disable the timer. A single response returns the residual count and a timeout flag. It sits between the pipeline's device bridge and the timer, so firmware issues one command instead of four bus accesses.

## Interface
- TIMEOUT_CYC, 1000: watchdog limit, in cycles spent in WAIT_IRQ.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_preset  in  32  value written to PRESET.
- cmd_mode  in  2  timer mode, placed in CTRL[2:1].
- cmd_wait  in  1  1 = wait for IRQ and read back; 0 = fire-and-forget.
- abort  in  1  cancel the operation in progress.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  response accepted.
- rsp_count  out  32  COUNT sampled at completion, or cmd_preset when cmd_wait=0.
- rsp_timeout  out  1  watchdog expired before IRQ.
- tmr_addr  out  2  timer register select: 00 CTRL, 01 PRESET, 10 COUNT.
- tmr_we  out  1  timer write strobe.
- tmr_wdata  out  32  timer write data.
- tmr_rdata  in  32  timer combinational read data (dataout).
- tmr_irq  in  1  timer interrupt (IRQ).

## Operation
- Command latch: cmd_preset, cmd_mode and cmd_wait are registered on cmd_valid & cmd_ready.
- States and transitions:
  - IDLE: on accept -> WR_PRESET.
  - WR_PRESET (addr 01, we 1, wdata = preset) -> WR_CTRL.
  - WR_CTRL (addr 00, we 1, wdata = {28'b0, IM=1, mode, EN=1}):
    - cmd_wait=1 -> WAIT_IRQ.
    - cmd_wait=0 -> RESP, with rsp_count = preset and rsp_timeout = 0.
  - WAIT_IRQ (we 0): the watchdog clears on entry and increments each cycle.
    - tmr_irq=1 -> RD_COUNT.
    - watchdog == TIMEOUT_CYC-1 with no IRQ -> RD_COUNT, setting the timeout flag.
  - RD_COUNT (addr 10, we 0): rsp_count <= tmr_rdata -> DISABLE.
  - DISABLE (addr 00, we 1, wdata = 0; clears EN and IM, dropping IRQ) -> RESP.
    - If entered via abort -> IDLE instead.
  - RESP: rsp_valid = 1; on rsp_ready -> IDLE.
- abort:
  - Honoured in WR_PRESET, WR_CTRL, WAIT_IRQ and RD_COUNT: next state is DISABLE, and no response is produced.
  - Ignored in IDLE, DISABLE and RESP.
- Simultaneous tmr_irq and watchdog expiry: IRQ wins, rsp_timeout = 0.
- Simultaneous abort and tmr_irq in WAIT_IRQ: abort wins.
- tmr_irq already high on entry to WAIT_IRQ: exit after exactly one cycle in WAIT_IRQ.
- Bus outputs (tmr_addr, tmr_we, tmr_wdata) are decoded from the state register only. In IDLE, WAIT_IRQ and RESP they are addr 00, we 0, wdata 0.

## Timing
- Reset values: cmd_ready 1, rsp_valid 0, rsp_count 0, rsp_timeout 0, tmr_addr 00, tmr_we 0, tmr_wdata 0, state IDLE, watchdog 0.
- Reset mid-operation aborts silently. No DISABLE write is issued; the timer has its own reset.
- Write latencies, counting accept at edge 0:
  - PRESET write is visible in cycle 1.
  - CTRL write is visible in cycle 2.
  - cmd_wait=0 gives rsp_valid in cycle 3.
- IRQ path: IRQ sampled at edge N gives RD_COUNT in cycle N+1, DISABLE in N+2 and rsp_valid in N+3.
- Timeout path: rsp_valid appears TIMEOUT_CYC + 2 cycles after entering WAIT_IRQ.
- Response handshake:
  - rsp_valid, rsp_count and rsp_timeout are stable while rsp_valid=1 and rsp_ready=0.
  - cmd_ready rises the cycle after the response handshake.
- There is no back-to-back overlap: at most one command is in flight.

## Structure
- Shared package:
  - Timer register address constants (CTRL 2'b00, PRESET 2'b01, COUNT 2'b10).
  - CTRL bit positions (EN 0, MODE 2:1, IM 3).
  - The state enum.
- One natural sub-module, `timer_watchdog`: a counter with clear and enable inputs, producing an expire pulse at TIMEOUT_CYC-1.

## Test plan
- COCO attached. Command preset=5, mode=0, wait=1 -> bus shows write 01/0x5, then write 00/0x9, IRQ, read of 10, write 00/0x0 -> rsp_count = COCO count value, rsp_timeout = 0.
- Command preset=7, wait=0 -> two writes only, rsp_valid in cycle 3, rsp_count = 7.
- Stub timer that never raises IRQ, TIMEOUT_CYC=16 -> rsp_timeout = 1, rsp_valid 18 cycles after entering WAIT_IRQ, DISABLE write observed.
- abort pulsed in WAIT_IRQ -> write 00/0x0 on the next cycle, then IDLE, no rsp_valid, cmd_ready = 1.
- IRQ and watchdog expiry in the same cycle -> rsp_timeout = 0. rsp_ready held low for 5 cycles -> response stable throughout, no new cmd accepted.
- reset asserted asynchronously mid-WR_CTRL -> all outputs return to reset values immediately; next command runs normally.
